keccak_perm_ctrl: RTL and testbench

KECCAK_PERM_CTRL -- requirements
Module: keccak_perm_ctrl

---
 rtl/keccak_perm_ctrl.sv | 149 ++++++++++++++
 tb/tb_keccak_perm_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/keccak_perm_ctrl.sv
// Keccak pi-permutation address sequencer: walks a DIM x DIM x SLICES bank, reading each cell
// and writing it to its permuted (or identity) slot. Define KECCAK_PERM_CTRL_PERF_EN for a cycle counter.
module keccak_perm_ctrl #(
   parameter int DIM    = 5,
   parameter int SLICES = 64,
   parameter int W      = 25,
   localparam int IW    = $clog2(DIM),
   localparam int AW    = $clog2(SLICES * DIM * DIM)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic          abort,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [W-1:0]  rd_data,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [W-1:0]  wr_data,
   output logic          busy,
   output logic          done
`ifdef KECCAK_PERM_CTRL_PERF_EN
  ,output logic [15:0]   cycles
`endif
);

   localparam int SW = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam int MW = IW + 3;
   localparam logic [AW-1:0] CELLS  = AW'(DIM * DIM);
   localparam logic [AW-1:0] DIM_A  = AW'(DIM);
   localparam logic [MW-1:0] DIM_M  = MW'(DIM);
   localparam logic [IW-1:0] LAST_C = IW'(DIM - 1);
   localparam logic [SW-1:0] LAST_S = SW'(SLICES - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RD, S_WR, S_SLICE, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] s_q, s_d;
   logic [IW-1:0] i_q, i_d;
   logic [IW-1:0] j_q, j_d;
   logic          mode_q, mode_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         s_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         i_q     <= i_d;
         j_q     <= j_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      i_d     = i_q;
      j_d     = j_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_LOAD;
               mode_d  = mode;
            end
         end
         S_LOAD: begin
            s_d     = '0;
            i_d     = '0;
            j_d     = '0;
            state_d = S_RD;
         end
         S_RD: state_d = S_WR;
         S_WR: begin
            if (i_q == LAST_C && j_q == LAST_C) begin
               state_d = S_SLICE;
            end else begin
               state_d = S_RD;
               if (j_q == LAST_C) begin
                  j_d = '0;
                  i_d = i_q + 1'b1;
               end else begin
                  j_d = j_q + 1'b1;
               end
            end
         end
         S_SLICE: begin
            i_d = '0;
            j_d = '0;
            if (s_q == LAST_S) begin
               state_d = S_DONE;
            end else begin
               s_d     = s_q + 1'b1;
               state_d = S_RD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort && state_q != S_IDLE) state_d = S_IDLE;
   end

   // (2i+3j) < 5*DIM, so four conditional subtractions give the exact residue.
   logic [MW-1:0] sum_m;
   logic [IW-1:0] ip, jp;
   always_comb begin
      sum_m = MW'(2) * MW'(i_q) + MW'(3) * MW'(j_q);
      for (int k = 0; k < 4; k++) begin
         if (sum_m >= DIM_M) sum_m = sum_m - DIM_M;
      end
      ip = mode_q ? i_q : j_q;
      jp = mode_q ? j_q : IW'(sum_m);
   end

   logic [AW-1:0] base;
   assign base    = AW'(s_q) * CELLS;
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign rd_en   = (state_q == S_RD);
   assign wr_en   = (state_q == S_WR);
   assign rd_addr = rd_en ? base + AW'(i_q) * DIM_A + AW'(j_q) : '0;
   assign wr_addr = wr_en ? base + AW'(ip) * DIM_A + AW'(jp) : '0;
   assign wr_data = wr_en ? rd_data : '0;

`ifdef KECCAK_PERM_CTRL_PERF_EN
   logic [15:0] cycles_q, cycles_d;

   always_comb begin
      cycles_d = cycles_q;
      if (state_q != S_IDLE && !abort) begin
         cycles_d = (state_q == S_LOAD) ? 16'd1 : cycles_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cycles_q <= '0;
      else     cycles_q <= cycles_d;
   end

   assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_keccak_perm_ctrl.sv
// Self-checking bench for keccak_perm_ctrl (DIM=5, SLICES=2, W=8) against a cell-order
// reference model; covers permutation, identity copy, abort, ignored start and mid-run reset.
module tb_keccak_perm_ctrl;

   localparam int DIM    = 5;
   localparam int SLICES = 2;
   localparam int W      = 8;
   localparam int AW     = $clog2(SLICES * DIM * DIM);

   logic          clk = 1'b0;
   logic          rst, start, mode, abort;
   logic          rd_en, wr_en, busy, done;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [W-1:0]  rd_data, wr_data;
`ifdef KECCAK_PERM_CTRL_PERF_EN
   logic [15:0]   cycles;
`endif

   keccak_perm_ctrl #(.DIM(DIM), .SLICES(SLICES), .W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done)
`ifdef KECCAK_PERM_CTRL_PERF_EN
     ,.cycles(cycles)
`endif
   );

   always #5 clk = ~clk;

   logic [W-1:0] mem [0:63];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int n_assert = 0;
   int n_fail   = 0;
   int exp_rd[$];
   int exp_wr[$];
   int wr_log[0:63];
   int done_k, nrd, nwr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected transfer list: raster order over slices, rows, columns.
   task automatic build(input bit m);
      exp_rd.delete();
      exp_wr.delete();
      for (int s = 0; s < SLICES; s++)
         for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
               exp_rd.push_back(s*DIM*DIM + i*DIM + j);
               if (m) exp_wr.push_back(s*DIM*DIM + i*DIM + j);
               else   exp_wr.push_back(s*DIM*DIM + j*DIM + ((2*i + 3*j) % DIM));
            end
   endtask

   task automatic run(input bit m, input int abort_wr, input int start_k, input int rst_k);
      int ka;
      bit stop;
      ka = 0;
      stop = 1'b0;
      build(m);
      done_k = 0; nrd = 0; nwr = 0;
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      @(posedge clk);
      for (int k = 1; k <= 300 && !stop; k++) begin
         @(negedge clk);
         start = (k == start_k);
         if (rd_en) begin
            if (nrd < exp_rd.size()) chk("rd_addr", 32'(rd_addr), 32'(exp_rd[nrd]));
            nrd++;
         end
         if (wr_en) begin
            if (nwr < exp_wr.size()) begin
               chk("wr_addr", 32'(wr_addr), 32'(exp_wr[nwr]));
               chk("wr_data", 32'(wr_data), 32'(mem[exp_rd[nwr]]));
               wr_log[nwr] = int'(wr_addr);
            end
            nwr++;
         end
         if (done) begin
            done_k = k;
            stop = 1'b1;
         end
         if (ka != 0 && k == ka + 1) begin
            abort = 1'b0;
            chk("busy_after_abort", 32'(busy), 32'd0);
         end
         if (wr_en && nwr == abort_wr) begin
            abort = 1'b1;
            ka = k;
         end
         if (ka != 0 && k == ka + 20) stop = 1'b1;
         if (k == rst_k) begin
            chk("busy_before_rst", 32'(busy), 32'd1);
            rst = 1'b1;
            #1;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rd_en", 32'(rd_en), 32'd0);
            chk("rst_wr_en", 32'(wr_en), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_rd_addr", 32'(rd_addr), 32'd0);
            chk("rst_wr_addr", 32'(wr_addr), 32'd0);
            chk("rst_wr_data", 32'(wr_data), 32'd0);
`ifdef KECCAK_PERM_CTRL_PERF_EN
            chk("rst_cycles", 32'(cycles), 32'd0);
`endif
         end
         if (rst_k != 0 && k == rst_k + 2) rst = 1'b0;
         if (rst_k != 0 && k == rst_k + 150) stop = 1'b1;
      end
      start = 1'b0;
      abort = 1'b0;
      if (done_k != 0) begin
         @(negedge clk);
         chk("done_one_cycle", 32'(done), 32'd0);
         chk("busy_after_done", 32'(busy), 32'd0);
      end
      $display("run mode=%0d done_at=%0d reads=%0d writes=%0d", m, done_k, nrd, nwr);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
      for (int a = 0; a < 64; a++) mem[a] = W'($urandom);
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rd_en", 32'(rd_en), 32'd0);
      chk("reset_wr_en", 32'(wr_en), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_rd_addr", 32'(rd_addr), 32'd0);
      chk("reset_wr_addr", 32'(wr_addr), 32'd0);
      chk("reset_wr_data", 32'(wr_data), 32'd0);
      rst = 1'b0;

      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", 32'(busy), 32'd0);
      @(negedge clk);
      chk("start_abort_idle2", 32'(busy), 32'd0);

      // Pi permutation, full run.
      run(1'b0, 0, 0, 0);
      chk("m0_latency", 32'(done_k), 32'd104);
      chk("m0_reads", 32'(nrd), 32'd50);
      chk("m0_writes", 32'(nwr), 32'd50);
      chk("m0_cell_1_0", 32'(wr_log[5]), 32'd2);
      chk("m0_cell_1_1", 32'(wr_log[6]), 32'd5);
      chk("m0_cell_4_4", 32'(wr_log[24]), 32'd20);
`ifdef KECCAK_PERM_CTRL_PERF_EN
      chk("m0_cycles", 32'(cycles), 32'd104);
      repeat (5) @(negedge clk);
      chk("m0_cycles_hold", 32'(cycles), 32'd104);
`endif

      // Identity copy with address-valued data.
      for (int a = 0; a < 64; a++) mem[a] = W'(a);
      run(1'b1, 0, 0, 0);
      chk("m1_latency", 32'(done_k), 32'd104);
      chk("m1_reads", 32'(nrd), 32'd50);
      chk("m1_writes", 32'(nwr), 32'd50);

      // Abort on the 10th write, then a full run.
      for (int a = 0; a < 64; a++) mem[a] = W'($urandom);
      run(1'b0, 10, 0, 0);
      chk("abort_no_done", 32'(done_k), 32'd0);
      chk("abort_reads", 32'(nrd), 32'd10);
      chk("abort_writes", 32'(nwr), 32'd10);
`ifdef KECCAK_PERM_CTRL_PERF_EN
      chk("abort_cycles_frozen", 32'(cycles), 32'd20);
`endif
      run(1'b0, 0, 0, 0);
      chk("post_abort_latency", 32'(done_k), 32'd104);
      chk("post_abort_writes", 32'(nwr), 32'd50);

      // Start while busy is ignored; reset mid-run discards the run.
      run(1'b0, 0, 20, 40);
      chk("rst_no_done", 32'(done_k), 32'd0);
      chk("rst_reads", 32'(nrd), 32'd20);
      chk("rst_writes", 32'(nwr), 32'd19);
      chk("rst_idle_after", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
